// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose:
//   Bundles every signal around the shared memory port arbiter. This covers
//   the instruction-fetch requester, the data load/store requester and the
//   backing-memory port. Clock and reset are not part of the bundle.
//
// Handshake semantics (all three channels):
//   - A requester raises x_req with its address and payload. It holds them
//     stable until it sees x_done=1.
//   - It must drop x_req during the cycle x_done is high. A request still
//     high afterwards counts as a new request.
//   - The arbiter raises m_req with a registered address, write enable and
//     write data, and holds them until m_ack.
//   - m_ack is a one-cycle pulse. m_rdata and m_err are only meaningful
//     while m_ack=1.
//   - x_rdata and x_err are only meaningful while x_done=1.
//   - x_wait is x_req & ~x_done. It is a combinational convenience for the
//     requester.
//
// Modports:
//   master : the arbiter. It serves requesters and drives the memory port.
//   slave  : the environment, made up of the requesters and the memory.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    logic              i_err;
    logic              i_wait;

    // Data load/store requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_err;
    logic              d_wait;

    // Backing-memory port
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;
    logic              m_err;

    modport master (
        input  i_req, i_addr,
        output i_rdata, i_done, i_err, i_wait,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_done, d_err, d_wait,
        output m_req, m_we, m_addr, m_wdata,
        input  m_rdata, m_ack, m_err
    );

    modport slave (
        output i_req, i_addr,
        input  i_rdata, i_done, i_err, i_wait,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_done, d_err, d_wait,
        input  m_req, m_we, m_addr, m_wdata,
        output m_rdata, m_ack, m_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one backing-memory port between the instruction-fetch requester
//   and the data load/store requester.
//   - Data wins contention by default.
//   - After STARVE_LIMIT consecutive data grants made while a fetch was
//     waiting, the fetch is forced through.
//   - A memory access that sees no m_ack for TIMEOUT cycles is aborted. The
//     requester then gets a done pulse with err=1 and rdata=0, and the
//     control path treats that as a segv.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : mem_port_arbiter_if.master. Carries the requester channels
//                and the memory port (see the interface header for the
//                handshake).
//   dbg_state  : current grant state
//                (0=IDLE, 1=BUSY_I, 2=BUSY_D, 3=DONE)
//   dbg_streak : current count of consecutive data grants made while a
//                fetch was pending
//
// Timing:
//   - Request sampled in IDLE at edge 0: m_req is high after edge 0.
//   - m_ack in cycle k: x_done is high in cycle k+1.
//   - Next arbitration happens in cycle k+2.
//
// Parameter constraints: STARVE_LIMIT >= 1, TIMEOUT >= 1.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    mem_port_arbiter_if.master                bus,
    output logic [1:0]                        dbg_state,
    output logic [$clog2(STARVE_LIMIT+1)-1:0] dbg_streak
);
    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam int TCNT_W   = $clog2(TIMEOUT + 1);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
    // The counter holds the number of BUSY cycles already completed without
    // an ack. Seeing TIMEOUT-1 here means the current cycle is the last one
    // allowed.
    localparam logic [TCNT_W-1:0]   TCNT_LAST  = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Registered state and its next-state values
    state_t              state_q,   state_d;
    logic [STREAK_W-1:0] streak_q,  streak_d;
    logic [TCNT_W-1:0]   tcnt_q,    tcnt_d;

    logic                m_req_q,   m_req_d;
    logic                m_we_q,    m_we_d;
    logic [ADDR_W-1:0]   m_addr_q,  m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;

    logic                i_done_q,  i_done_d;
    logic                i_err_q,   i_err_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;

    logic                d_done_q,  d_done_d;
    logic                d_err_q,   d_err_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic                data_wins;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            streak_q  <= '0;
            tcnt_q    <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_done_q  <= 1'b0;
            i_err_q   <= 1'b0;
            i_rdata_q <= '0;
            d_done_q  <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            tcnt_q    <= tcnt_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_done_q  <= i_done_d;
            i_err_q   <= i_err_d;
            i_rdata_q <= i_rdata_d;
            d_done_q  <= d_done_d;
            d_err_q   <= d_err_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // Hold everything by default. The done pulses default low, so each
        // one lasts exactly the single DONE cycle.
        state_d   = state_q;
        streak_d  = streak_q;
        tcnt_d    = tcnt_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_done_d  = 1'b0;
        i_err_d   = i_err_q;
        i_rdata_d = i_rdata_q;
        d_done_d  = 1'b0;
        d_err_d   = d_err_q;
        d_rdata_d = d_rdata_q;

        // Data wins any contention unless the fetch has waited through a
        // full streak of data grants.
        data_wins = bus.d_req & (~bus.i_req | (streak_q != STREAK_MAX));

        case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                if (data_wins) begin
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    state_d   = ST_BUSY_D;
                    // The streak only grows while a fetch is actually waiting.
                    if (bus.i_req) begin
                        streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX
                                                            : streak_q + STREAK_W'(1);
                    end else begin
                        streak_d = '0;
                    end
                end else if (bus.i_req) begin
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = bus.i_addr;
                    m_wdata_d = '0;
                    state_d   = ST_BUSY_I;
                    streak_d  = '0;
                end
            end

            ST_BUSY_I, ST_BUSY_D: begin
                // An ack in the final allowed cycle takes priority over the
                // abort.
                if (bus.m_ack) begin
                    m_req_d = 1'b0;
                    state_d = ST_DONE;
                    if (state_q == ST_BUSY_I) begin
                        i_done_d  = 1'b1;
                        i_err_d   = bus.m_err;
                        i_rdata_d = bus.m_rdata;
                    end else begin
                        d_done_d = 1'b1;
                        d_err_d  = bus.m_err;
                        // A store returns no data, so d_rdata keeps its
                        // previous load result.
                        if (!m_we_q) begin
                            d_rdata_d = bus.m_rdata;
                        end
                    end
                end else if (tcnt_q == TCNT_LAST) begin
                    m_req_d = 1'b0;
                    state_d = ST_DONE;
                    if (state_q == ST_BUSY_I) begin
                        i_done_d  = 1'b1;
                        i_err_d   = 1'b1;
                        i_rdata_d = '0;
                    end else begin
                        d_done_d  = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end

            ST_DONE: begin
                tcnt_d  = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;

    assign bus.i_done  = i_done_q;
    assign bus.i_err   = i_err_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.i_wait  = bus.i_req & ~i_done_q;

    assign bus.d_done  = d_done_q;
    assign bus.d_err   = d_err_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.d_wait  = bus.d_req & ~d_done_q;

    assign dbg_state   = state_q;
    assign dbg_streak  = streak_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Testbench for mem_port_arbiter.
//
// Reference model:
//   - Tracks the requests each requester has pending, plus the streak of
//     data wins taken while a fetch waited.
//   - Tracks the last result each requester was given.
//
// Stimulus:
//   - Inputs are driven and outputs sampled 1 time unit after each rising
//     edge.
//   - The memory side is played by the serve task, with a chosen ack delay.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 5;
    localparam int SW = $clog2(SL + 1);

    logic          clk;
    logic          rst_n;
    logic [1:0]    dbg_state;
    logic [SW-1:0] dbg_streak;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_streak(dbg_streak)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model state ----------------
    bit          ip, dp;           // pending fetch / data request
    logic [31:0] ia, da, dw;
    logic        dwe;
    int          streak_m;
    logic [31:0] exp_i_rdata, exp_d_rdata;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        bus.i_req   = ip;
        bus.i_addr  = ia;
        bus.d_req   = dp;
        bus.d_we    = dwe;
        bus.d_addr  = da;
        bus.d_wdata = dw;
    endtask

    task automatic new_d(input logic we, input logic [31:0] a, input logic [31:0] w);
        dp  = 1'b1;
        dwe = we;
        da  = a;
        dw  = w;
    endtask

    // Runs one complete transaction from IDLE.
    // Memory acks in BUSY cycle delay+1. When that is past TO, no ack is
    // given and the access must time out.
    task automatic serve(input int delay, input logic [31:0] rd, input logic er,
                         output bit win_d);
        bit          acked;
        logic [31:0] wa;
        win_d = dp && !(ip && streak_m == SL);
        wa    = win_d ? da : ia;
        drive_reqs();
        step();
        chk("grant_m_req",   bus.m_req, 1);
        chk("grant_m_addr",  bus.m_addr, wa);
        chk("grant_m_we",    bus.m_we, win_d ? dwe : 1'b0);
        chk("grant_m_wdata", bus.m_wdata, win_d ? dw : 32'h0);
        if (win_d) streak_m = ip ? ((streak_m + 1 > SL) ? SL : streak_m + 1) : 0;
        else       streak_m = 0;
        chk("grant_streak", dbg_streak, streak_m);

        acked = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            chk("busy_m_req", bus.m_req, 1);
            chk("busy_no_done", {bus.i_done, bus.d_done}, 2'b00);
            if (c == delay + 1) begin
                bus.m_ack   = 1'b1;
                bus.m_rdata = rd;
                bus.m_err   = er;
                acked       = 1'b1;
            end else begin
                bus.m_rdata = $urandom();
            end
            step();
            bus.m_ack = 1'b0;
            bus.m_err = 1'b0;
            if (acked) break;
        end

        // Now in the DONE cycle.
        chk("done_m_req", bus.m_req, 0);
        chk("done_i_done", bus.i_done, !win_d);
        chk("done_d_done", bus.d_done, win_d);
        if (win_d) begin
            if (!acked)    exp_d_rdata = 32'h0;
            else if (!dwe) exp_d_rdata = rd;
            chk("done_d_err", bus.d_err, acked ? er : 1'b1);
        end else begin
            exp_i_rdata = acked ? rd : 32'h0;
            chk("done_i_err", bus.i_err, acked ? er : 1'b1);
        end
        chk("done_i_rdata", bus.i_rdata, exp_i_rdata);
        chk("done_d_rdata", bus.d_rdata, exp_d_rdata);
        chk("done_i_wait", bus.i_wait, ip && win_d);
        chk("done_d_wait", bus.d_wait, dp && !win_d);

        if (win_d) dp = 1'b0;
        else       ip = 1'b0;
        drive_reqs();
        step();
        chk("idle_dones", {bus.i_done, bus.d_done}, 2'b00);
        chk("idle_m_req", bus.m_req, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit win;
        int nd;
        bit seen_i;

        ip = 0; dp = 0; ia = 0; da = 0; dw = 0; dwe = 0;
        streak_m = 0; exp_i_rdata = 0; exp_d_rdata = 0;
        bus.m_ack = 1'b0; bus.m_err = 1'b0; bus.m_rdata = '0;
        drive_reqs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) step();

        // Reset state
        chk("rst_m_req",   bus.m_req, 0);
        chk("rst_m_we",    bus.m_we, 0);
        chk("rst_m_addr",  bus.m_addr, 0);
        chk("rst_m_wdata", bus.m_wdata, 0);
        chk("rst_dones",   {bus.i_done, bus.d_done}, 2'b00);
        chk("rst_errs",    {bus.i_err, bus.d_err}, 2'b00);
        chk("rst_i_rdata", bus.i_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_state",   dbg_state, 0);
        chk("rst_streak",  dbg_streak, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_no_req_m_req", bus.m_req, 0);

        // Lone fetch, acked in 2nd BUSY cycle
        ip = 1; ia = 32'h100;
        serve(1, 32'hDEADBEEF, 1'b0, win);
        chk("fetch_winner", win, 0);

        // Load, then store: store must leave d_rdata unchanged
        new_d(1'b0, 32'h44, 32'h0);
        serve(2, 32'h55AA55AA, 1'b0, win);
        new_d(1'b1, 32'h40, 32'h12345678);
        serve(0, 32'hCAFEF00D, 1'b0, win);
        chk("store_winner", win, 1);

        // Starvation: fetch held, data re-asserted after every d_done
        ip = 1; ia = 32'h200; nd = 0; seen_i = 0;
        for (int k = 0; k < 6; k++) begin
            if (!dp) new_d(1'b0, 32'h300 + 32'(k * 4), 32'h0);
            serve($urandom_range(0, 2), $urandom(), 1'b0, win);
            if (!win) seen_i = 1;
            else if (!seen_i) nd++;
        end
        chk("starve_d_before_i", nd, SL);
        chk("starve_i_served", seen_i, 1);

        // Timeout on a load, then a late ack two cycles after d_done
        new_d(1'b0, 32'h80, 32'h0);
        serve(TO, 32'h0, 1'b0, win);
        step();
        bus.m_ack = 1'b1; bus.m_rdata = 32'hBADBAD00; bus.m_err = 1'b1;
        step();
        bus.m_ack = 1'b0; bus.m_err = 1'b0;
        chk("late_ack_m_req",  bus.m_req, 0);
        chk("late_ack_d_done", bus.d_done, 0);
        chk("late_ack_d_rdata", bus.d_rdata, 32'h0);
        chk("late_ack_state",  dbg_state, 0);

        // Ack in the very last allowed BUSY cycle counts as success
        new_d(1'b0, 32'h8C, 32'h0);
        serve(TO - 1, 32'h77778888, 1'b0, win);

        // Memory fault on fetch, then a clean data load
        ip = 1; ia = 32'h104;
        serve(0, 32'h11112222, 1'b1, win);
        new_d(1'b0, 32'h88, 32'h0);
        serve(1, 32'h33334444, 1'b0, win);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            if (!ip && !dp) repeat ($urandom_range(0, 2)) step();
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1; ia = $urandom();
            end
            if (!dp && $urandom_range(0, 1) == 1) begin
                new_d(1'($urandom_range(0, 1)), $urandom(), $urandom());
            end
            if (!ip && !dp) new_d(1'b0, $urandom(), $urandom());
            serve($urandom_range(0, TO), $urandom(), ($urandom_range(0, 3) == 0), win);
        end

        // Reset mid-op with the streak at its limit
        for (int k = 0; k < 4 && (ip || dp); k++) serve(0, $urandom(), 1'b0, win);
        ip = 1; ia = 32'h500;
        for (int k = 0; k < SL - 1; k++) begin
            new_d(1'b0, 32'h600 + 32'(k * 4), 32'h0);
            serve(0, $urandom(), 1'b0, win);
        end
        new_d(1'b0, 32'hC0, 32'h0);
        drive_reqs();
        step();
        chk("pre_rst_m_addr", bus.m_addr, 32'hC0);
        chk("pre_rst_streak", dbg_streak, SL);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_m_req", bus.m_req, 0);
        chk("rst_async_streak", dbg_streak, 0);
        ip = 0; dp = 0; streak_m = 0; exp_i_rdata = 0; exp_d_rdata = 0;
        drive_reqs();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_no_done", {bus.i_done, bus.d_done}, 2'b00);
        chk("post_rst_state", dbg_state, 0);
        ip = 1; ia = 32'h400;
        new_d(1'b1, 32'hD0, 32'h0000ABCD);
        serve(0, $urandom(), 1'b0, win);
        chk("post_rst_data_wins", win, 1);
        serve(0, $urandom(), 1'b0, win);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one backing-memory port between the instruction-fetch requester and the data load/store requester feeding the MMU.
- Runs a grant state machine with a req/ack handshake to memory.
- Prefers data accesses, with an anti-starvation limit so fetch always progresses.
- Enforces an ack timeout that reports a fault, which the control path treats as a segv.

Parameters:
ADDR_W, 32, address width of requester and memory ports
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive data grants allowed while i_req is pending before instr is forced
TIMEOUT, 255, cycles in BUSY without m_ack before abort (must be >=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held until i_done
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetched word, valid while i_done=1
i_done  out  1  one-cycle completion pulse
i_err  out  1  fault flag, valid with i_done
i_wait  out  1  i_req & ~i_done (combinational)
d_req  in  1  data request; held until d_done
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid while d_done=1
d_done  out  1  one-cycle completion pulse
d_err  out  1  fault flag, valid with d_done
d_wait  out  1  d_req & ~d_done (combinational)
m_req  out  1  memory request, registered
m_we  out  1  memory write enable, registered
m_addr  out  ADDR_W  memory address, registered
m_wdata  out  DATA_W  memory write data, registered
m_rdata  in  DATA_W  memory read data, sampled with m_ack
m_ack  in  1  one-cycle completion from memory
m_err  in  1  memory fault, sampled with m_ack

Behaviour:

Reset (async, rst_n=0):
- State IDLE; streak counter = 0; timeout counter = 0.
- All registered outputs are 0: m_req, m_we, m_addr, m_wdata, i_done, d_done, i_err, d_err, i_rdata, d_rdata.
- Reset mid-transaction drops m_req immediately. The outstanding request is lost and no done pulse is issued.

States: IDLE, BUSY_I, BUSY_D, DONE.

IDLE:
- With no requests, stay in IDLE.
- Winner selection:
  - If only one of i_req/d_req is high, that requester wins.
  - If both are high, data wins, unless streak == STARVE_LIMIT, in which case instr wins.
- On a grant:
  - Latch m_addr, m_we (d_we for data, 0 for instr) and m_wdata (d_wdata for data, 0 for instr).
  - Set m_req=1 and go to BUSY_x. All take effect at the next edge.

Streak counter:
- A data grant made while i_req=1 increments streak, saturating at STARVE_LIMIT.
- Any instr grant clears streak to 0.
- A data grant with i_req=0 clears streak to 0.

BUSY_x:
- m_req stays 1; the timeout counter increments each cycle.
- On m_ack=1:
  - Clear m_req and go to DONE.
  - Register x_done=1 and x_err=m_err.
  - For instr, and for data when m_we=0: register x_rdata=m_rdata.
  - A data store leaves d_rdata unchanged.
- Timeout: if m_ack has not arrived after TIMEOUT cycles in BUSY, clear m_req and go to DONE with x_err=1 and x_rdata=0. An m_ack arriving after the abort is ignored.
- m_ack on the same cycle as the TIMEOUT limit is treated as success.
- m_ack in IDLE or DONE is ignored.

DONE:
- Lasts one cycle; x_done=1 for exactly this cycle.
- Then x_done=0, the timeout counter clears, and the state returns to IDLE.
- The requester must drop x_req in the DONE cycle. A req still high in IDLE is treated as a new request.

Latency:
- req sampled high in IDLE at edge 0 → m_req high after edge 0.
- m_ack in cycle k → x_done high in cycle k+1.
- Next arbitration takes place in cycle k+2.
- Minimum round trip is 3 cycles.

Other rules:
- Requester inputs are ignored outside IDLE. Address and data are latched only at grant.
- m_addr, m_we and m_wdata hold their last values when m_req=0.

Test Plan:
- Lone fetch: i_req=1, i_addr=0x100; m_ack in the 2nd BUSY cycle with m_rdata=0xDEADBEEF → m_addr=0x100, m_we=0; i_done pulses 1 cycle, i_rdata=0xDEADBEEF, i_err=0.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678; m_ack next cycle → m_we=1, m_wdata=0x12345678, d_done pulse, d_rdata unchanged.
- Contention/starvation with STARVE_LIMIT=4: i_req held high and d_req re-asserted after every d_done → grant order D,D,D,D,I,D…; d_done count is 4 before the first i_done.
- Timeout with TIMEOUT=5: d_req load, m_ack never asserted → m_req high for exactly 5 cycles, then d_done=1, d_err=1, d_rdata=0. A late m_ack two cycles after d_done is ignored.
- Memory fault: fetch acked with m_err=1 → i_done=1 with i_err=1; the next data request is served normally with d_err=0.
- Reset mid-op: assert rst_n=0 in BUSY_D → m_req=0 immediately with no clock; after release the state is IDLE and streak=0, so a simultaneous i_req/d_req is granted to data.
